shift_arb_ctrl: RTL and testbench
=================================

SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, serial frame length in bits (legal 2..32).
REQ-002 SHALL have parameter GAP, default 1, idle cycles inserted after each frame (legal 0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports req0, req1  input  1 each  transfer request from requester 0 / 1, held until granted.
REQ-006 SHALL have ports data0, data1  input  WIDTH each  parallel word to transmit, sampled at the grant edge.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  one-cycle pulse, word accepted.
REQ-008 SHALL have port so  output  1  serial data out, MSB first.
REQ-009 SHALL have port sen  output  1  shift enable; high exactly during the WIDTH bit cycles.
REQ-010 SHALL have port si  input  1  serial data in, sampled on each edge while sen=1.
REQ-011 SHALL have port rx_data  output  WIDTH  last completed captured frame.
REQ-012 SHALL have ports done0, done1  output  1 each  one-cycle pulse, owner's frame complete.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE, GAP; all outputs registered.
REQ-015 IDLE: on an edge with req0|req1, latch winner's data into tx register, set owner, pulse that gnt next cycle, enter SHIFT with bit count 0.
REQ-016 Arbitration SHALL be round-robin: single request wins; if both, the requester not granted last wins; after reset requester 0 has priority.
REQ-017 A request deasserted before its grant SHALL be dropped without side effects.
REQ-018 SHALL drive so=tx[WIDTH-1] and sen=1 in SHIFT; each edge shifts tx left by one (zero fill), shifts si into rx LSB, and increments count.
REQ-019 SHALL leave SHIFT after exactly WIDTH cycles; the bit-to-bit latency from grant pulse to first so bit is 0 cycles (same cycle).
REQ-020 DONE (one cycle): rx_data SHALL update with the captured word (first si bit at MSB), done of owner pulses, sen=0.
REQ-021 SHALL then spend GAP cycles in GAP (skipped when GAP=0) before IDLE; requests are only evaluated in IDLE.
REQ-022 so SHALL be 0 whenever sen=0; rx_data SHALL hold its value until the next DONE.
REQ-023 Back-to-back: with both requests held continuously, grants SHALL alternate 0,1,0,1 with frame period WIDTH+GAP+2 cycles.
REQ-024 gnt and done for the same requester SHALL never be high in the same cycle; gnt0 and gnt1 are mutually exclusive, likewise done0/done1.

Reset
REQ-025 While rst=0, state=IDLE, count=0, tx=0, rx=0, rx_data=0, owner=0, round-robin pointer favouring requester 0, and gnt0/gnt1/so/sen/done0/done1/busy=0, immediately (no clock edge required).
REQ-026 Reset asserted mid-frame SHALL abort the transfer with no done pulse; after release the block starts in IDLE.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration and the default WIDTH/GAP constants.
REQ-028 The round-robin arbiter SHALL be a sub-module rr_arb2 (inputs req0, req1, update strobe; outputs one-hot grant); shift datapath stays in shift_arb_ctrl.

Verification (WIDTH=8, GAP=1)
REQ-029 Reset: hold rst=0 with random inputs -> all outputs 0; assert rst=0 asynchronously mid-cycle -> outputs clear before next edge.
REQ-030 Single transfer: req0=1, data0=8'hA5, si looped from so -> gnt0 one cycle, so sequence 1,0,1,0,0,1,0,1 with sen=1 for 8 cycles, done0 pulse, rx_data=8'hA5.
REQ-031 Contention: req0 and req1 high from reset, data0=8'h0F, data1=8'hF0 -> gnt0 first, gnt1 next, frame starts 11 cycles apart, done0 then done1.
REQ-032 Capture: req1=1, data1=8'h00, si driven 1,1,0,0,1,0,1,1 -> done1, rx_data=8'hCB, so stays 0.
REQ-033 Abort: req0 with data0=8'hFF, assert rst at bit 4 -> no done0, rx_data=0, next req1 served normally.
REQ-034 Dropped request: pulse req1 for one cycle while busy -> no gnt1 after the current frame; busy returns 0.

Source files
------------

// File: rtl/shift_arb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_arb_ctrl_pkg
// Description : Shared FSM state encoding, counter type and default sizing
//               for the shift_arb_ctrl serial transfer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_arb_ctrl_pkg;

    // FSM state encoding (explicit 2-bit width)
    typedef logic [1:0] state_t;
    localparam state_t c_S_IDLE  = 2'd0;
    localparam state_t c_S_SHIFT = 2'd1;
    localparam state_t c_S_DONE  = 2'd2;
    localparam state_t c_S_GAP   = 2'd3;

    // Default frame length and inter-frame idle gap
    localparam int c_WIDTH_DEFAULT = 8;
    localparam int c_GAP_DEFAULT   = 1;

    // Shared bit/gap counter; 6 bits covers WIDTH up to 32 and GAP up to 15
    localparam int c_CNT_W = 6;
    typedef logic [c_CNT_W-1:0] cnt_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. Grant is combinational and
//               one-hot; the priority pointer advances on the update strobe
//               so the requester just served loses the next tie.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic clk,
    input  logic rst,      // asynchronous, active-low
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic gnt0,
    output logic gnt1
);

    // 1 = requester 1 wins a tie, 0 = requester 0 wins a tie
    logic r_prio1;

    // One-hot grant: lone requester wins, ties broken by the pointer
    always_comb begin
        gnt0 = req0 & (~req1 | ~r_prio1);
        gnt1 = req1 & (~req0 | r_prio1);
    end

    // Pointer moves to favour the requester that was not just granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio1 <= 1'b0;
        end else if (update) begin
            r_prio1 <= gnt0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_arb_ctrl
// Description : Arbitrates two parallel-word requesters onto one serial link.
//               The granted word is shifted out MSB first while the serial
//               input is captured, followed by a one-cycle DONE and an
//               optional idle gap. All outputs come straight from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arb_ctrl
    import shift_arb_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int GAP   = c_GAP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active-low
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             so,
    output logic             sen,
    input  logic             si,
    output logic [WIDTH-1:0] rx_data,
    output logic             done0,
    output logic             done1,
    output logic             busy
);

    localparam cnt_t c_LAST_BIT = cnt_t'(WIDTH - 1);
    localparam cnt_t c_LAST_GAP = cnt_t'(GAP - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    cnt_t             r_cnt;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-2:0] r_rx;
    logic [WIDTH-1:0] w_rx_shift;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_owner;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_sen;
    logic             r_done0;
    logic             r_done1;
    logic             r_busy;
    logic             w_arb_upd;
    logic             w_arb_g0;
    logic             w_arb_g1;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .update (w_arb_upd),
        .gnt0   (w_arb_g0),
        .gnt1   (w_arb_g1)
    );

    // Receive word including the bit arriving on this edge; the top bit of
    // the previous shift value falls off, so r_rx only keeps WIDTH-1 bits.
    assign w_rx_shift = {r_rx, si};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; requests are only looked at while idle
    always_comb begin
        w_state_nxt = r_state;
        w_arb_upd   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (req0 | req1) begin
                    w_state_nxt = c_S_SHIFT;
                    w_arb_upd   = 1'b1;
                end
            end
            c_S_SHIFT: begin
                if (r_cnt == c_LAST_BIT) begin
                    w_state_nxt = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_state_nxt = (GAP == 0) ? c_S_IDLE : c_S_GAP;
            end
            c_S_GAP: begin
                if (r_cnt == c_LAST_GAP) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. tx is zero-filled as it shifts, so
    // its MSB is already 0 whenever no frame is on the wire and can drive so
    // directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_owner   <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_sen     <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_busy  <= (w_state_nxt != c_S_IDLE);
            case (r_state)
                c_S_IDLE: begin
                    if (w_arb_upd) begin
                        r_tx    <= w_arb_g1 ? data1 : data0;
                        r_owner <= w_arb_g1;
                        r_gnt0  <= w_arb_g0;
                        r_gnt1  <= w_arb_g1;
                        r_sen   <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                c_S_SHIFT: begin
                    r_tx <= {r_tx[WIDTH-2:0], 1'b0};
                    r_rx <= w_rx_shift[WIDTH-2:0];
                    if (r_cnt == c_LAST_BIT) begin
                        r_sen     <= 1'b0;
                        r_rx_data <= w_rx_shift;
                        r_done0   <= ~r_owner;
                        r_done1   <= r_owner;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + cnt_t'(1);
                    end
                end
                c_S_DONE: begin
                    r_cnt <= '0;
                end
                c_S_GAP: begin
                    r_cnt <= r_cnt + cnt_t'(1);
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign so      = r_tx[WIDTH-1];
    assign sen     = r_sen;
    assign rx_data = r_rx_data;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_shift_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arb_ctrl
// Description : Directed self-checking bench for shift_arb_ctrl, WIDTH=8,
//               GAP=1. Outputs are sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arb_ctrl;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       gnt0;
    logic       gnt1;
    logic       so;
    logic       sen;
    logic       si;
    logic [7:0] rx_data;
    logic       done0;
    logic       done1;
    logic       busy;

    int n_total;
    int n_bad;

    shift_arb_ctrl #(.WIDTH(8), .GAP(1)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .data0   (data0),
        .data1   (data1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .so      (so),
        .sen     (sen),
        .si      (si),
        .rx_data (rx_data),
        .done0   (done0),
        .done1   (done1),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Control outputs packed as {gnt0,gnt1,so,sen,done0,done1,busy}
    function automatic logic [6:0] ctl();
        return {gnt0, gnt1, so, sen, done0, done1, busy};
    endfunction

    logic exp_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic drv_cb [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int seen;
        int dcnt;
        int t_g0, t_g1, t_g0b, t_d0, t_d1, n_g0, n_g1, viol;
        logic so_g0, so_g1;

        n_total = 0;
        n_bad   = 0;
        rst   = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        si    = 1'b0;

        // ---------------- reset with random inputs ----------------
        for (int i = 0; i < 6; i++) begin
            req0  = 1'($urandom);
            req1  = 1'($urandom);
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            si    = 1'($urandom);
            step();
            chk("rst_ctl", 32'(ctl()), 32'h0);
            chk("rst_rx", 32'(rx_data), 32'h0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        si   = 1'b0;
        rst  = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'h0);

        // ---------------- single transfer, loopback ----------------
        req0  = 1'b1;
        data0 = 8'hA5;
        step();
        req0 = 1'b0;
        chk("s_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("s_gnt0", 32'(gnt0), (i == 0) ? 32'h1 : 32'h0);
            chk("s_gnt1", 32'(gnt1), 32'h0);
            chk("s_sen", 32'(sen), 32'h1);
            chk("s_so", 32'(so), 32'(exp_a5[i]));
            chk("s_nodone", 32'(done0), 32'h0);
            si = so;
            step();
        end
        chk("s_done0", 32'(done0), 32'h1);
        chk("s_sen_off", 32'(sen), 32'h0);
        chk("s_so_off", 32'(so), 32'h0);
        chk("s_rx", 32'(rx_data), 32'hA5);
        si = 1'b0;
        step();
        chk("s_gap_busy", 32'(busy), 32'h1);
        chk("s_done_pulse", 32'(done0), 32'h0);
        step();
        chk("s_idle", 32'(ctl()), 32'h0);
        chk("s_rx_hold", 32'(rx_data), 32'hA5);

        // ---------------- capture with so held at 0 ----------------
        req1  = 1'b1;
        data1 = 8'h00;
        step();
        req1 = 1'b0;
        chk("c_gnt1", 32'(gnt1), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("c_so", 32'(so), 32'h0);
            chk("c_sen", 32'(sen), 32'h1);
            si = drv_cb[i];
            step();
        end
        chk("c_done1", 32'(done1), 32'h1);
        chk("c_done0", 32'(done0), 32'h0);
        chk("c_rx", 32'(rx_data), 32'hCB);
        si = 1'b0;
        step();
        step();
        chk("c_idle", 32'(busy), 32'h0);

        // ---------------- dropped request while busy ----------------
        req0  = 1'b1;
        data0 = 8'h3C;
        si    = 1'b1;
        step();
        req0 = 1'b0;
        chk("d_gnt0", 32'(gnt0), 32'h1);
        seen = 0;
        dcnt = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k == 3) req1 = 1'b1;
            if (k == 4) req1 = 1'b0;
            step();
            if (gnt1) seen++;
            if (done0) dcnt++;
        end
        chk("d_no_gnt1", 32'(seen), 32'h0);
        chk("d_done0_cnt", 32'(dcnt), 32'h1);
        chk("d_busy", 32'(busy), 32'h0);
        chk("d_rx", 32'(rx_data), 32'hFF);

        // ---------------- abort mid-frame ----------------
        req0  = 1'b1;
        data0 = 8'hFF;
        si    = 1'b1;
        step();
        req0 = 1'b0;
        chk("a_gnt0", 32'(gnt0), 32'h1);
        for (int i = 0; i < 4; i++) step();
        chk("a_bit4_sen", 32'(sen), 32'h1);
        chk("a_bit4_so", 32'(so), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("a_async_ctl", 32'(ctl()), 32'h0);
        chk("a_async_rx", 32'(rx_data), 32'h0);
        step();
        rst = 1'b1;
        si  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done0 || busy) dcnt++;
        end
        chk("a_no_done0", 32'(dcnt), 32'h0);
        chk("a_rx_zero", 32'(rx_data), 32'h0);
        req1  = 1'b1;
        data1 = 8'h5A;
        step();
        req1 = 1'b0;
        chk("a_gnt1", 32'(gnt1), 32'h1);
        for (int i = 0; i < 8; i++) begin
            si = so;
            step();
        end
        chk("a_done1", 32'(done1), 32'h1);
        chk("a_rx", 32'(rx_data), 32'h5A);
        si = 1'b0;
        step();
        step();

        // ---------------- contention from reset ----------------
        rst   = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'h0F;
        data1 = 8'hF0;
        step();
        chk("k_rst_ctl", 32'(ctl()), 32'h0);
        rst = 1'b1;
        t_g0 = -100; t_g1 = -100; t_g0b = -100; t_d0 = -100; t_d1 = -100;
        n_g0 = 0; n_g1 = 0; viol = 0;
        so_g0 = 1'bx; so_g1 = 1'bx;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step();
            if ((gnt0 && gnt1) || (done0 && done1) || (gnt0 && done0) || (gnt1 && done1))
                viol++;
            if (gnt0) begin
                if (n_g0 == 0) begin t_g0 = cyc; so_g0 = so; end
                else if (n_g0 == 1) t_g0b = cyc;
                n_g0++;
            end
            if (gnt1) begin
                if (n_g1 == 0) begin t_g1 = cyc; so_g1 = so; end
                n_g1++;
            end
            if (done0 && t_d0 < 0) t_d0 = cyc;
            if (done1 && t_d1 < 0) t_d1 = cyc;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("k_t_g0", 32'(t_g0), 32'd1);
        chk("k_t_g1", 32'(t_g1), 32'd12);
        chk("k_t_g0b", 32'(t_g0b), 32'd23);
        chk("k_t_d0", 32'(t_d0), 32'd9);
        chk("k_t_d1", 32'(t_d1), 32'd20);
        chk("k_so_g0", 32'(so_g0), 32'h0);
        chk("k_so_g1", 32'(so_g1), 32'h1);
        chk("k_excl", 32'(viol), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
